// File: rtl/video_stream_pkg.sv
// ---------------------------------------------------------------------------
// video_stream_pkg
// Shared types and constants for the AXI4-Stream video pattern source.
//   state_t        : sequencing FSM states (also exported as a debug output)
//   pattern_mode_t : test pattern selection
//   CHECKER_SHIFT  : log2 of the checkerboard square size (8x8 squares)
// ---------------------------------------------------------------------------
package video_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HBLANK = 2'd2,
      ST_VBLANK = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      MODE_HRAMP   = 2'd0,
      MODE_VRAMP   = 2'd1,
      MODE_CHECKER = 2'd2,
      MODE_CONST   = 2'd3
   } pattern_mode_t;

   localparam int CHECKER_SHIFT = 3;

endpackage

// File: rtl/video_pattern_lane.sv
// ---------------------------------------------------------------------------
// video_pattern_lane
// Combinational pixel generator for one lane of a beat.
//   mode  : pattern select
//   x     : pixel column of this lane
//   y     : pixel row
//   level : value used by the constant pattern
//   pixel : generated N-bit pixel
// ---------------------------------------------------------------------------
module video_pattern_lane
   import video_stream_pkg::*;
#(
   parameter int N     = 8,
   parameter int DIM_W = 13
) (
   input  pattern_mode_t    mode,
   input  logic [DIM_W-1:0] x,
   input  logic [DIM_W-1:0] y,
   input  logic [N-1:0]     level,
   output logic [N-1:0]     pixel
);

   always_comb begin
      pixel = '0;
      case (mode)
         MODE_HRAMP:   pixel = N'(x);
         MODE_VRAMP:   pixel = N'(y);
         // Square colour flips every 2^CHECKER_SHIFT pixels in both axes.
         MODE_CHECKER: pixel = {N{x[CHECKER_SHIFT] ^ y[CHECKER_SHIFT]}};
         default:      pixel = level;
      endcase
   end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// axis_video_pattern_gen
// AXI4-Stream video source with programmable frame size, blanking and
// test pattern, PPC pixels per beat, and single-shot TLAST/TUSER drop.
//
// Ports
//   sys_clk, sys_reset        : clock, synchronous active-high reset
//   cfg_*                     : run configuration, latched on accepted start
//   start                     : one-cycle pulse that starts a run
//   inject_drop_tlast/tuser   : arm suppression of the next TLAST / TUSER
//   busy                      : run in progress
//   frame_done                : pulse on VBLANK entry (last beat accepted)
//   cfg_err                   : pulse when a start is rejected
//   m_axis_*                  : AXI4-Stream master (tuser = SOF, tlast = EOL)
//   fsm_state                 : current sequencing state, for debug
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. Once tvalid is high, tdata/tlast/tuser are held until that
// transfer and tvalid never falls without it.
// ---------------------------------------------------------------------------
module axis_video_pattern_gen
   import video_stream_pkg::*;
#(
   parameter int N     = 8,
   parameter int PPC   = 1,
   parameter int DIM_W = 13
) (
   input  logic             sys_clk,
   input  logic             sys_reset,
   input  logic [DIM_W-1:0] cfg_width,
   input  logic [DIM_W-1:0] cfg_height,
   input  logic [7:0]       cfg_hblank,
   input  logic [15:0]      cfg_vblank,
   input  logic [1:0]       cfg_mode,
   input  logic [N-1:0]     cfg_const,
   input  logic [7:0]       cfg_frames,
   input  logic             start,
   input  logic             inject_drop_tlast,
   input  logic             inject_drop_tuser,
   output logic             busy,
   output logic             frame_done,
   output logic             cfg_err,
   output logic [N*PPC-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic             m_axis_tuser,
   output state_t           fsm_state
);

   // ---------------- registers ----------------
   state_t           state, state_n;
   logic [DIM_W-1:0] x, x_n, y, y_n;
   logic [15:0]      cnt, cnt_n;
   logic [7:0]       frames_left, frames_n;
   logic             busy_n, tvalid_n, frame_done_n, cfg_err_n;
   logic             load, launch;

   logic [DIM_W-1:0] width_l, height_l;
   logic [7:0]       hblank_l, frames_l;
   logic [15:0]      vblank_l;
   pattern_mode_t    mode_l;
   logic [N-1:0]     const_l;

   logic             arm_tlast, arm_tlast_n, arm_tuser, arm_tuser_n;
   logic             sup_tlast, sup_tlast_n, sup_tuser, sup_tuser_n;
   logic [N*PPC-1:0] tdata_n;
   logic             tlast_n, tuser_n;

   // ---------------- derived conditions ----------------
   logic             accept, cfg_ok, line_end, last_line, last_frame, run_done;
   logic             returning_idle, load_line_end, load_sof;
   logic [DIM_W-1:0] width_use;
   pattern_mode_t    mode_use;
   logic [N-1:0]     const_use;
   logic [N*PPC-1:0] lane_pix;

   assign accept     = m_axis_tvalid & m_axis_tready;
   assign cfg_ok     = (cfg_width >= DIM_W'(PPC)) &&
                       ((cfg_width % DIM_W'(PPC)) == '0) &&
                       (cfg_height != '0);
   assign line_end   = (x == width_l - DIM_W'(PPC));
   assign last_line  = (y == height_l - 1'b1);
   // last_frame is evaluated before the end-of-frame decrement,
   // run_done after it (while sitting in VBLANK).
   assign last_frame = (frames_l != 8'd0) && (frames_left == 8'd1);
   assign run_done   = (frames_l != 8'd0) && (frames_left == 8'd0);

   // On the launch edge the config registers are not loaded yet, so the
   // first beat is built from the live config inputs.
   assign width_use  = (state == ST_IDLE) ? cfg_width : width_l;
   assign mode_use   = (state == ST_IDLE) ? pattern_mode_t'(cfg_mode) : mode_l;
   assign const_use  = (state == ST_IDLE) ? cfg_const : const_l;

   assign fsm_state  = state;

   // ---------------- FSM next state / control ----------------
   always_comb begin
      state_n      = state;
      x_n          = x;
      y_n          = y;
      cnt_n        = cnt;
      frames_n     = frames_left;
      busy_n       = busy;
      tvalid_n     = m_axis_tvalid;
      frame_done_n = 1'b0;
      cfg_err_n    = 1'b0;
      load         = 1'b0;
      launch       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  launch   = 1'b1;
                  load     = 1'b1;
                  state_n  = ST_ACTIVE;
                  x_n      = '0;
                  y_n      = '0;
                  frames_n = cfg_frames;
                  busy_n   = 1'b1;
                  tvalid_n = 1'b1;
               end else begin
                  cfg_err_n = 1'b1;
               end
            end
         end

         ST_ACTIVE: begin
            if (accept) begin
               if (!line_end) begin
                  x_n  = x + DIM_W'(PPC);
                  load = 1'b1;
               end else begin
                  x_n = '0;
                  if (!last_line) begin
                     y_n = y + 1'b1;
                     if (hblank_l == 8'd0) begin
                        load = 1'b1;
                     end else begin
                        state_n  = ST_HBLANK;
                        tvalid_n = 1'b0;
                        cnt_n    = 16'(hblank_l);
                     end
                  end else begin
                     y_n          = '0;
                     frame_done_n = 1'b1;
                     if (frames_l != 8'd0) frames_n = frames_left - 8'd1;
                     if (vblank_l == 16'd0) begin
                        // Zero blanking: VBLANK entry and exit share this edge.
                        if (last_frame) begin
                           state_n  = ST_IDLE;
                           busy_n   = 1'b0;
                           tvalid_n = 1'b0;
                        end else begin
                           load = 1'b1;
                        end
                     end else begin
                        state_n  = ST_VBLANK;
                        tvalid_n = 1'b0;
                        cnt_n    = vblank_l;
                     end
                  end
               end
            end
         end

         // cnt holds the number of idle cycles still to be shown,
         // including the current one.
         ST_HBLANK: begin
            if (cnt == 16'd1) begin
               state_n  = ST_ACTIVE;
               load     = 1'b1;
               tvalid_n = 1'b1;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end

         ST_VBLANK: begin
            if (cnt == 16'd1) begin
               if (run_done) begin
                  state_n = ST_IDLE;
                  busy_n  = 1'b0;
               end else begin
                  state_n  = ST_ACTIVE;
                  load     = 1'b1;
                  tvalid_n = 1'b1;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end

         default: state_n = ST_IDLE;
      endcase
   end

   // ---------------- pixel lanes (next beat position) ----------------
   for (genvar k = 0; k < PPC; k++) begin : g_lane
      video_pattern_lane #(
         .N     (N),
         .DIM_W (DIM_W)
      ) u_lane (
         .mode  (mode_use),
         .x     (x_n + DIM_W'(k)),
         .y     (y_n),
         .level (const_use),
         .pixel (lane_pix[k*N +: N])
      );
   end

   // ---------------- injection flags and output beat ----------------
   assign returning_idle = (state != ST_IDLE) && (state_n == ST_IDLE);
   assign load_line_end  = (x_n == width_use - DIM_W'(PPC));
   assign load_sof       = (x_n == '0) && (y_n == '0);

   always_comb begin
      // An armed flag clears only once the beat it actually suppressed is
      // accepted; a pulse arriving while armed (or on that edge) is absorbed.
      arm_tlast_n = arm_tlast;
      if (returning_idle)             arm_tlast_n = 1'b0;
      else if (accept && sup_tlast)   arm_tlast_n = 1'b0;
      else if (inject_drop_tlast)     arm_tlast_n = 1'b1;

      arm_tuser_n = arm_tuser;
      if (returning_idle)             arm_tuser_n = 1'b0;
      else if (accept && sup_tuser)   arm_tuser_n = 1'b0;
      else if (inject_drop_tuser)     arm_tuser_n = 1'b1;

      tdata_n     = m_axis_tdata;
      tlast_n     = m_axis_tlast;
      tuser_n     = m_axis_tuser;
      sup_tlast_n = sup_tlast;
      sup_tuser_n = sup_tuser;

      if (load) begin
         tdata_n     = lane_pix;
         tlast_n     = load_line_end & ~arm_tlast_n;
         sup_tlast_n = load_line_end &  arm_tlast_n;
         tuser_n     = load_sof & ~arm_tuser_n;
         sup_tuser_n = load_sof &  arm_tuser_n;
      end else if (!tvalid_n) begin
         tlast_n     = 1'b0;
         tuser_n     = 1'b0;
         sup_tlast_n = 1'b0;
         sup_tuser_n = 1'b0;
      end
   end

   // ---------------- state register ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state         <= ST_IDLE;
         x             <= '0;
         y             <= '0;
         cnt           <= '0;
         frames_left   <= '0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         cfg_err       <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         arm_tlast     <= 1'b0;
         arm_tuser     <= 1'b0;
         sup_tlast     <= 1'b0;
         sup_tuser     <= 1'b0;
      end else begin
         state         <= state_n;
         x             <= x_n;
         y             <= y_n;
         cnt           <= cnt_n;
         frames_left   <= frames_n;
         busy          <= busy_n;
         frame_done    <= frame_done_n;
         cfg_err       <= cfg_err_n;
         m_axis_tvalid <= tvalid_n;
         m_axis_tdata  <= tdata_n;
         m_axis_tlast  <= tlast_n;
         m_axis_tuser  <= tuser_n;
         arm_tlast     <= arm_tlast_n;
         arm_tuser     <= arm_tuser_n;
         sup_tlast     <= sup_tlast_n;
         sup_tuser     <= sup_tuser_n;
      end
   end

   // ---------------- latched run configuration ----------------
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         width_l  <= '0;
         height_l <= '0;
         hblank_l <= '0;
         vblank_l <= '0;
         frames_l <= '0;
         mode_l   <= MODE_HRAMP;
         const_l  <= '0;
      end else if (launch) begin
         width_l  <= cfg_width;
         height_l <= cfg_height;
         hblank_l <= cfg_hblank;
         vblank_l <= cfg_vblank;
         frames_l <= cfg_frames;
         mode_l   <= pattern_mode_t'(cfg_mode);
         const_l  <= cfg_const;
      end
   end

endmodule
